// File: rtl/logic_op_pkg.sv
// logic_op_pkg: shared opcodes, FSM encoding and default widths for the logic-op issuer
package logic_op_pkg;
    localparam int LU_W       = 32;
    localparam int OP_W       = 3;
    localparam int FIFO_DEPTH = 4;

    localparam logic [OP_W-1:0] OP_AND  = 3'b000;
    localparam logic [OP_W-1:0] OP_XOR  = 3'b001;
    localparam logic [OP_W-1:0] OP_NAND = 3'b010;
    localparam logic [OP_W-1:0] OP_OR   = 3'b011;
    localparam logic [OP_W-1:0] OP_NOTA = 3'b100;
    localparam logic [OP_W-1:0] OP_NOR  = 3'b101;
    localparam logic [OP_W-1:0] OP_NEGA = 3'b110;
    localparam logic [OP_W-1:0] OP_XNOR = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;
endpackage

// File: rtl/logic_op_issuer_if.sv
// logic_op_issuer_if: command, logic-unit and result bundle of the logic-op issuer
//   cmd_*      : request port (valid/ready) from decode
//   lu_*       : registered operands to the combinational logic unit, lu_c back
//   res_*      : captured result with valid/ready backpressure
//   fifo_count : command FIFO occupancy
interface logic_op_issuer_if
    import logic_op_pkg::*;
#(
    parameter int W     = LU_W,
    parameter int DEPTH = FIFO_DEPTH
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            cmd_valid;
    logic            cmd_ready;
    logic [OP_W-1:0] cmd_op;
    logic [W-1:0]    cmd_a;
    logic [W-1:0]    cmd_b;
    logic [OP_W-1:0] lu_op;
    logic [W-1:0]    lu_a;
    logic [W-1:0]    lu_b;
    logic [W-1:0]    lu_c;
    logic            res_valid;
    logic            res_ready;
    logic [W-1:0]    res_data;
    logic [OP_W-1:0] res_op;
    logic [CW-1:0]   fifo_count;

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, lu_c, res_ready,
        output cmd_ready, lu_op, lu_a, lu_b, res_valid, res_data, res_op, fifo_count
    );

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, lu_c, res_ready,
        input  cmd_ready, lu_op, lu_a, lu_b, res_valid, res_data, res_op, fifo_count
    );
endinterface

// File: rtl/logic_cmd_fifo.sv
// logic_cmd_fifo: DEPTH-entry synchronous FIFO of {op, a, b} commands
//   clk/rst    : clock, async active-high reset
//   push/din   : write when push (caller guarantees !full)
//   pop/dout   : head entry, advanced when pop (caller guarantees !empty)
//   full/empty/count : occupancy status
module logic_cmd_fifo
    import logic_op_pkg::*;
#(
    parameter int W     = LU_W,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [OP_W+2*W-1:0]       din,
    input  logic                      pop,
    output logic [OP_W+2*W-1:0]       dout,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = OP_W + 2 * W;

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;

    // pointers are exactly AW bits wide, so increments wrap modulo DEPTH
    always_comb begin
        wr_d  = push ? wr_q + AW'(1) : wr_q;
        rd_d  = pop ? rd_q + AW'(1) : rd_q;
        cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= din;
    end

    assign dout  = mem_q[rd_q];
    assign full  = cnt_q == (AW+1)'(DEPTH);
    assign empty = cnt_q == '0;
    assign count = cnt_q;
endmodule

// File: rtl/logic_op_issuer.sv
// logic_op_issuer: buffers logic-op requests, issues them to the logic unit and returns results
//   clk/rst : clock, async active-high reset
//   bus     : slave view of logic_op_issuer_if (cmd_*, lu_*, res_*, fifo_count)
module logic_op_issuer
    import logic_op_pkg::*;
#(
    parameter int W     = LU_W,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    logic_op_issuer_if.slave   bus
);
    localparam int EW = OP_W + 2 * W;
    localparam int CW = $clog2(DEPTH) + 1;

    state_t          state_q, state_d;
    logic [OP_W-1:0] lu_op_q, lu_op_d, res_op_q, res_op_d;
    logic [W-1:0]    lu_a_q, lu_a_d, lu_b_q, lu_b_d, res_data_q, res_data_d;
    logic            res_valid_q, res_valid_d;
    logic            push, pop, full, empty;
    logic [EW-1:0]   head;
    logic [CW-1:0]   count;

    // no pass-through: a full FIFO refuses even when a pop happens this cycle
    assign push = bus.cmd_valid && !full;

    logic_cmd_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   ({bus.cmd_op, bus.cmd_a, bus.cmd_b}),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        lu_op_d     = lu_op_q;
        lu_a_d      = lu_a_q;
        lu_b_d      = lu_b_q;
        res_op_d    = res_op_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        case (state_q)
            ST_IDLE: begin
                pop     = !empty;
                state_d = empty ? ST_IDLE : ST_ISSUE;
            end
            ST_ISSUE: begin
                // lu_* have been stable all cycle, so lu_c is settled here
                res_data_d  = bus.lu_c;
                res_op_d    = lu_op_q;
                res_valid_d = 1'b1;
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                if (res_valid_q && bus.res_ready) begin
                    res_valid_d = 1'b0;
                    pop         = !empty;
                    state_d     = empty ? ST_IDLE : ST_ISSUE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (pop) {lu_op_d, lu_a_d, lu_b_d} = head;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            lu_op_q     <= '0;
            lu_a_q      <= '0;
            lu_b_q      <= '0;
            res_op_q    <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lu_op_q     <= lu_op_d;
            lu_a_q      <= lu_a_d;
            lu_b_q      <= lu_b_d;
            res_op_q    <= res_op_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign bus.cmd_ready  = !full;
    assign bus.fifo_count = count;
    assign bus.lu_op      = lu_op_q;
    assign bus.lu_a       = lu_a_q;
    assign bus.lu_b       = lu_b_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_data   = res_data_q;
    assign bus.res_op     = res_op_q;
endmodule

// File: tb/tb_logic_op_issuer.sv
// tb_logic_op_issuer: scoreboard bench for logic_op_issuer with a behavioural logic unit
module tb_logic_op_issuer;
    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    int   res_cyc[$];
    exp_t mon_e;
    logic [31:0] tbl [8] = '{32'h00000098, 32'h00000067, 32'hFFFFFF67, 32'h000000FF,
                             32'hFFFFFF24, 32'hFFFFFF00, 32'hFFFFFF25, 32'hFFFFFF98};

    logic_op_issuer_if #(.W(32), .DEPTH(4)) bus ();

    logic_op_issuer #(.W(32), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // stand-in for the team's logic unit, written gate-style
    always_comb begin
        bus.lu_c = '0;
        case (bus.lu_op)
            3'd0: bus.lu_c = ~(~bus.lu_a | ~bus.lu_b);
            3'd1: bus.lu_c = (bus.lu_a | bus.lu_b) & ~(bus.lu_a & bus.lu_b);
            3'd2: bus.lu_c = ~bus.lu_a | ~bus.lu_b;
            3'd3: bus.lu_c = ~(~bus.lu_a & ~bus.lu_b);
            3'd4: bus.lu_c = ~bus.lu_a;
            3'd5: bus.lu_c = ~bus.lu_a & ~bus.lu_b;
            3'd6: bus.lu_c = ~bus.lu_a + 32'd1;
            default: bus.lu_c = (bus.lu_a & bus.lu_b) | (~bus.lu_a & ~bus.lu_b);
        endcase
    end

    function automatic logic [31:0] ref_lu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0: return a & b;
            3'd1: return a ^ b;
            3'd2: return 32'hFFFFFFFF - (a & b);
            3'd3: return a | b;
            3'd4: return 32'hFFFFFFFF - a;
            3'd5: return 32'hFFFFFFFF - (a | b);
            3'd6: return 32'd0 - a;
            default: return 32'hFFFFFFFF - (a ^ b);
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
        chk({tag, "_count"}, 32'(bus.fifo_count), 32'd0);
        chk({tag, "_lu_op"}, 32'(bus.lu_op), 32'd0);
        chk({tag, "_lu_a"}, bus.lu_a, 32'd0);
        chk({tag, "_lu_b"}, bus.lu_b, 32'd0);
        chk({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
        chk({tag, "_res_data"}, bus.res_data, 32'd0);
        chk({tag, "_res_op"}, 32'(bus.res_op), 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
    endtask

    task automatic push_rand(input int n);
        for (int i = 0; i < n; i++) begin
            set_cmd(3'($urandom_range(0, 7)), $urandom, $urandom);
            step();
        end
        bus.cmd_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int k;
        bus.res_ready = 1'b1;
        for (k = 0; k < 80 && (exp_q.size() != 0 || bus.res_valid); k++) step();
        chk(name, 32'(exp_q.size() != 0 || bus.res_valid), 32'd0);
    endtask

    // monitor: outputs are stable mid-cycle, inputs change just after posedge
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.res_valid && bus.res_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected got %h op %0d want nothing", bus.res_data, bus.res_op);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("sb_data", bus.res_data, mon_e.data);
                    chk("sb_op", 32'(bus.res_op), 32'(mon_e.op));
                    res_cyc.push_back(cyc);
                end
            end
            if (bus.cmd_valid && bus.cmd_ready)
                exp_q.push_back('{op: bus.cmd_op, data: ref_lu(bus.cmd_op, bus.cmd_a, bus.cmd_b)});
        end
    end

    initial begin
        logic [2:0]  f_op;
        logic [31:0] f_a, f_b, r_a, r_b;
        int n0, k;
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.res_ready = 1'b0;
        repeat (3) step();
        check_reset("rst");
        rst = 1'b0;
        step();

        // one command per opcode, fixed operands, latency of 2 edges
        bus.res_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_cmd(3'(i), 32'h000000DB, 32'h000000BC);
            step();
            bus.cmd_valid = 1'b0;
            step();
            chk("lat_n1_valid", 32'(bus.res_valid), 32'd0);
            step();
            chk("lat_n2_valid", 32'(bus.res_valid), 32'd1);
            chk("tbl_data", bus.res_data, tbl[i]);
            chk("tbl_op", 32'(bus.res_op), 32'(i));
            step();
        end

        // fill with backpressure
        bus.res_ready = 1'b0;
        f_op = 3'($urandom_range(0, 7));
        f_a  = $urandom;
        f_b  = $urandom;
        for (int i = 0; i < 5; i++) begin
            if (i == 0) set_cmd(f_op, f_a, f_b);
            else set_cmd(3'($urandom_range(0, 7)), $urandom, $urandom);
            chk("fill_ready", 32'(bus.cmd_ready), 32'd1);
            step();
        end
        chk("full_ready", 32'(bus.cmd_ready), 32'd0);
        chk("full_count", 32'(bus.fifo_count), 32'd4);
        chk("full_held_valid", 32'(bus.res_valid), 32'd1);
        set_cmd(3'($urandom_range(0, 7)), $urandom, $urandom);
        step();
        step();
        bus.cmd_valid = 1'b0;
        chk("refused_count", 32'(bus.fifo_count), 32'd4);
        chk("refused_ready", 32'(bus.cmd_ready), 32'd0);
        chk("held_data", bus.res_data, ref_lu(f_op, f_a, f_b));
        chk("held_op", 32'(bus.res_op), 32'(f_op));

        // drain: ready returns at the first pop, results every 2 cycles
        n0 = res_cyc.size();
        bus.res_ready = 1'b1;
        step();
        chk("drain_ready", 32'(bus.cmd_ready), 32'd1);
        chk("drain_count", 32'(bus.fifo_count), 32'd3);
        for (k = 0; k < 30 && res_cyc.size() < n0 + 5; k++) step();
        chk("drain_done", 32'(res_cyc.size() >= n0 + 5), 32'd1);
        if (res_cyc.size() >= n0 + 5)
            for (int i = 1; i < 5; i++) chk("drain_spacing", 32'(res_cyc[n0+i] - res_cyc[n0+i-1]), 32'd2);
        drain("drain_empty");

        // simultaneous push and pop while holding with 2 queued
        bus.res_ready = 1'b0;
        push_rand(3);
        chk("sim_pre_count", 32'(bus.fifo_count), 32'd2);
        chk("sim_pre_valid", 32'(bus.res_valid), 32'd1);
        bus.res_ready = 1'b1;
        set_cmd(3'($urandom_range(0, 7)), $urandom, $urandom);
        step();
        bus.cmd_valid = 1'b0;
        chk("sim_count", 32'(bus.fifo_count), 32'd2);
        drain("sim_drain");

        // reset during ISSUE with 3 queued
        bus.res_ready = 1'b0;
        push_rand(5);
        chk("rst_pre_full", 32'(bus.fifo_count), 32'd4);
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        chk("rst_pre_count", 32'(bus.fifo_count), 32'd3);
        chk("rst_pre_issue", 32'(bus.res_valid), 32'd0);
        rst = 1'b1;
        exp_q.delete();
        #1;
        check_reset("midrst");
        step();
        rst = 1'b0;
        bus.res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("post_rst_quiet", 32'(bus.res_valid), 32'd0);
        end
        f_op = 3'($urandom_range(0, 7));
        r_a  = $urandom;
        r_b  = $urandom;
        set_cmd(f_op, r_a, r_b);
        step();
        bus.cmd_valid = 1'b0;
        step();
        chk("post_rst_n1", 32'(bus.res_valid), 32'd0);
        step();
        chk("post_rst_n2", 32'(bus.res_valid), 32'd1);
        chk("post_rst_data", bus.res_data, ref_lu(f_op, r_a, r_b));
        chk("post_rst_op", 32'(bus.res_op), 32'(f_op));
        drain("post_rst_drain");

        // random traffic
        for (int i = 0; i < 400; i++) begin
            bus.cmd_valid = 1'($urandom_range(0, 1));
            bus.cmd_op    = 3'($urandom_range(0, 7));
            bus.cmd_a     = $urandom;
            bus.cmd_b     = $urandom;
            bus.res_ready = ($urandom % 4) != 0;
            step();
        end
        bus.cmd_valid = 1'b0;
        drain("rand_drain");
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
